fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of instruction, address and PC buses.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 stallF  input  1  downstream hold: IF/ID register not enabled this cycle.
REQ-006 redirect  input  1  branch/jump taken; restart fetch at redirect_pc.
REQ-007 redirect_pc  input  DATA_WIDTH  new fetch target.
REQ-008 imem_req  output  1  instruction memory request valid.
REQ-009 imem_addr  output  DATA_WIDTH  request address, word aligned.
REQ-010 imem_gnt  input  1  request accepted this cycle.
REQ-011 imem_rvalid  input  1  read data valid; one response per grant, in order, ≥1 cycle after grant.
REQ-012 imem_rdata  input  DATA_WIDTH  instruction word.
REQ-013 instrF  output  DATA_WIDTH  fetched instruction to IF/ID register.
REQ-014 PCF  output  DATA_WIDTH  address of instrF.
REQ-015 PCPlus4F  output  DATA_WIDTH  PCF + 4.
REQ-016 validF  output  1  instrF/PCF/PCPlus4F hold a valid instruction.

Function
REQ-017 FSM states SHALL be REQ, WAIT, OUT; at most one memory request outstanding.
REQ-018 REQ: imem_req=1, imem_addr=pc_q; on imem_gnt latch req_pc=pc_q, go WAIT; else stay REQ.
REQ-019 WAIT: imem_req=0; on imem_rvalid with kill=0, register instrF=imem_rdata, PCF=req_pc, PCPlus4F=req_pc+4, validF=1, go OUT.
REQ-020 WAIT: on imem_rvalid with kill=1, discard data, clear kill, go REQ; outputs unchanged, validF stays 0.
REQ-021 OUT: validF=1; if stallF=1 hold all outputs and stay OUT; if stallF=0 the instruction is consumed: pc_q=PCF+4, validF=0, go REQ.
REQ-022 validF SHALL be 1 only in OUT; consumption occurs on a cycle with validF=1 and stallF=0.
REQ-023 redirect=1 SHALL take priority over stallF and all FSM transitions: pc_q={redirect_pc[31:2],2'b00}, validF=0, instrF/PCF/PCPlus4F=0 on the next edge.
REQ-024 redirect in REQ without gnt: stay REQ; imem_addr changes to the new target next cycle (retarget before grant is legal).
REQ-025 redirect in REQ with gnt same cycle: go WAIT with kill=1 (granted fetch is stale).
REQ-026 redirect in WAIT: set kill=1, stay WAIT; if imem_rvalid same cycle, discard data and go REQ with kill=0.
REQ-027 redirect in OUT: go REQ.
REQ-028 A second redirect while kill=1 SHALL only update pc_q; exactly one response is still discarded.
REQ-029 PC arithmetic SHALL be modulo 2^DATA_WIDTH; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-030 imem_addr[1:0] SHALL always be 2'b00.
REQ-031 Throughput without stalls SHALL be one instruction per (1 + grant wait + response latency + 1) cycles; no prefetch.

Reset
REQ-032 While rst_n=0: state=REQ, pc_q=RESET_PC, kill=0, validF=0, instrF=0, PCF=0, PCPlus4F=0, imem_req=0.
REQ-033 imem_req SHALL assert on the first rising edge after rst_n deasserts, with imem_addr=RESET_PC.
REQ-034 Reset asserted mid-transaction SHALL abandon the outstanding request; the memory model is reset together with the unit.

Verification
REQ-035 Reset release, gnt immediate, rvalid 1 cycle later with 32'h0000_0093 -> validF=1, instrF=32'h0000_0093, PCF=0, PCPlus4F=4; next request addr=4.
REQ-036 OUT with stallF=1 for 3 cycles -> outputs and validF stable for 3 cycles, imem_req=0; stallF=0 -> request at PCF+4.
REQ-037 Redirect to 32'h0000_0100 in WAIT (req addr 8) -> rdata for addr 8 discarded, validF never 1 for PC=8, next imem_addr=32'h100.
REQ-038 Redirect with redirect_pc=32'h0000_0203 concurrent with gnt -> one response discarded, next imem_addr=32'h0000_0200.
REQ-039 Redirect and stallF=1 both in OUT -> validF=0 next cycle, imem_req=1 at redirect target.
REQ-040 RESET_PC=32'hFFFF_FFFC, consume first instruction -> PCPlus4F=0, next imem_addr=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding request to instruction memory,
// presents the fetched word to the IF/ID register and supports redirects.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stallF,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instrF,
    output logic [DATA_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0] PCPlus4F,
    output logic                  validF
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~{{(DATA_WIDTH-2){1'b0}}, 2'b11};
    localparam logic [DATA_WIDTH-1:0] FOUR       = {{(DATA_WIDTH-3){1'b0}}, 3'b100};

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_reqPc;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [DATA_WIDTH-1:0] r_pcF;
    logic [DATA_WIDTH-1:0] r_pcPlus4;
    logic                  r_valid;
    logic                  r_kill;
    logic                  r_live;

    logic                  w_grant;
    logic [DATA_WIDTH-1:0] w_redirectPc;

    // r_live holds the request off until the first clock edge after reset release
    assign imem_req     = r_live && (r_state == S_REQ);
    assign imem_addr    = r_pc & ALIGN_MASK;
    assign w_grant      = imem_req && imem_gnt;
    assign w_redirectPc = redirect_pc & ALIGN_MASK;

    assign instrF   = r_instr;
    assign PCF      = r_pcF;
    assign PCPlus4F = r_pcPlus4;
    assign validF   = r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_REQ;
            r_pc      <= RESET_PC;
            r_reqPc   <= '0;
            r_instr   <= '0;
            r_pcF     <= '0;
            r_pcPlus4 <= '0;
            r_valid   <= 1'b0;
            r_kill    <= 1'b0;
            r_live    <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (redirect) begin
                // A kill marks the single in-flight response as stale
                r_pc      <= w_redirectPc;
                r_valid   <= 1'b0;
                r_instr   <= '0;
                r_pcF     <= '0;
                r_pcPlus4 <= '0;
                case (r_state)
                    S_REQ: begin
                        if (w_grant) begin
                            r_state <= S_WAIT;
                            r_kill  <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            r_state <= S_REQ;
                            r_kill  <= 1'b0;
                        end else begin
                            r_kill <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_REQ;
                        r_kill  <= 1'b0;
                    end
                endcase
            end else begin
                case (r_state)
                    S_REQ: begin
                        if (w_grant) begin
                            r_reqPc <= r_pc;
                            r_state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            if (r_kill) begin
                                r_kill  <= 1'b0;
                                r_state <= S_REQ;
                            end else begin
                                r_instr   <= imem_rdata;
                                r_pcF     <= r_reqPc;
                                r_pcPlus4 <= r_reqPc + FOUR;
                                r_valid   <= 1'b1;
                                r_state   <= S_OUT;
                            end
                        end
                    end
                    S_OUT: begin
                        if (!stallF) begin
                            r_pc    <= r_pcPlus4;
                            r_valid <= 1'b0;
                            r_state <= S_REQ;
                        end
                    end
                    default: begin
                        r_state <= S_REQ;
                        r_valid <= 1'b0;
                        r_kill  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a memory model plus a program-order PC
// model, driven by directed scenarios and random gnt/latency/stall/redirect.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stallF = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instrF, PCF, PCPlus4F;
    logic        validF;

    logic        gnt2 = 1'b0, rvalid2 = 1'b0;
    logic [31:0] rdata2 = '0;
    logic        req2, validF2;
    logic [31:0] addr2, instrF2, PCF2, PCPlus4F2;

    fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .stallF(stallF), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instrF(instrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .validF(validF)
    );

    fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n), .stallF(1'b0), .redirect(1'b0),
        .redirect_pc(32'h0), .imem_req(req2), .imem_addr(addr2),
        .imem_gnt(gnt2), .imem_rvalid(rvalid2), .imem_rdata(rdata2),
        .instrF(instrF2), .PCF(PCF2), .PCPlus4F(PCPlus4F2), .validF(validF2)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          consumed = 0;
    int          memLat = 1;
    logic [31:0] expPc = 32'h0;
    bit          lastRedirect = 1'b0;
    bit          pending = 1'b0;
    int          pendCnt = 0;
    logic [31:0] pendAddr = '0;

    function automatic logic [31:0] memFn(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check against the models, drive inputs, predict the edge
    task automatic applyStimulus(input bit g, input bit st, input bit rd, input logic [31:0] rpc);
        @(negedge clk);
        checkOutput("addrAlign", 32'(imem_addr[1:0]), 32'd0);
        if (imem_req) begin
            checkOutput("reqAddr", imem_addr, expPc);
            checkOutput("oneOutstanding", 32'(pending), 32'd0);
        end
        if (validF) begin
            checkOutput("pcF", PCF, expPc);
            checkOutput("instrF", instrF, memFn(expPc));
            checkOutput("pcPlus4F", PCPlus4F, expPc + 32'd4);
        end
        if (lastRedirect) begin
            checkOutput("redirValid", 32'(validF), 32'd0);
            checkOutput("redirInstr", instrF, 32'd0);
            checkOutput("redirPcF", PCF, 32'd0);
            checkOutput("redirPc4", PCPlus4F, 32'd0);
        end
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (pending) begin
            if (pendCnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memFn(pendAddr);
            end else begin
                pendCnt--;
            end
        end
        imem_gnt    = g;
        stallF      = st;
        redirect    = rd;
        redirect_pc = rpc;
        if (imem_rvalid) pending = 1'b0;
        if (imem_req && imem_gnt) begin
            pending  = 1'b1;
            pendAddr = imem_addr;
            pendCnt  = memLat - 1;
        end
        if (redirect) begin
            expPc        = rpc & ~32'h3;
            lastRedirect = 1'b1;
        end else begin
            lastRedirect = 1'b0;
            if (validF && !stallF) begin
                expPc = expPc + 32'd4;
                consumed++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic randomCycle();
        memLat = $urandom_range(1, 3);
        applyStimulus($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 30,
                      $urandom_range(0, 99) < 5, $urandom());
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstValid", 32'(validF), 32'd0);
        checkOutput("rstReq", 32'(imem_req), 32'd0);
        checkOutput("rstInstr", instrF, 32'd0);
        checkOutput("rstPcF", PCF, 32'd0);
        checkOutput("rstPc4", PCPlus4F, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reqBeforeEdge", 32'(imem_req), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("firstReq", 32'(imem_req), 32'd1);
        checkOutput("firstAddr", imem_addr, 32'h0);
        checkOutput("dut2FirstAddr", addr2, 32'hFFFF_FFFC);

        // First fetch: immediate grant, one-cycle response
        memLat = 1;
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("firstValid", 32'(validF), 32'd1);
        checkOutput("firstInstr", instrF, 32'h0000_0093);
        checkOutput("firstPcF", PCF, 32'h0);
        checkOutput("firstPc4", PCPlus4F, 32'h4);

        // Three stalled cycles hold the outputs
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0);
            checkOutput("stallValid", 32'(validF), 32'd1);
            checkOutput("stallInstr", instrF, 32'h0000_0093);
            checkOutput("stallReq", 32'(imem_req), 32'd0);
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("afterConsumeReq", 32'(imem_req), 32'd1);
        checkOutput("afterConsumeAddr", imem_addr, 32'h4);

        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("addr8", imem_addr, 32'h8);

        // Redirect while waiting on the response for address 8
        memLat = 2;
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 1, 32'h0000_0100);
        checkOutput("waitRedirReq", 32'(imem_req), 32'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("discardValid", 32'(validF), 32'd0);
        checkOutput("redirAddr100", imem_addr, 32'h100);
        checkOutput("redirReq100", 32'(imem_req), 32'd1);

        // Redirect concurrent with grant, unaligned target
        memLat = 1;
        applyStimulus(1, 0, 1, 32'h0000_0203);
        checkOutput("gntRedirReq", 32'(imem_req), 32'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("gntRedirValid", 32'(validF), 32'd0);
        checkOutput("gntRedirAddr", imem_addr, 32'h200);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("pc200Valid", 32'(validF), 32'd1);
        checkOutput("pc200PcF", PCF, 32'h200);

        // Redirect beats stall in OUT
        applyStimulus(0, 1, 1, 32'h0000_0040);
        checkOutput("outRedirValid", 32'(validF), 32'd0);
        checkOutput("outRedirReq", 32'(imem_req), 32'd1);
        checkOutput("outRedirAddr", imem_addr, 32'h40);

        // Double redirect with a single stale response in flight
        memLat = 3;
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 1, 32'h0000_0080);
        applyStimulus(0, 0, 1, 32'h0000_00C0);
        memLat = 1;
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0);
        checkOutput("doubleRedirAddr", imem_addr, 32'hC0);
        checkOutput("doubleRedirReq", 32'(imem_req), 32'd1);

        for (int i = 0; i < 1500; i++) randomCycle();
        checkOutput("progress", 32'(consumed >= 100), 32'd1);

        // Asynchronous reset in the middle of a transaction
        for (int i = 0; i < 50 && !pending; i++) randomCycle();
        checkOutput("midResetSetup", 32'(pending), 32'd1);
        #2;
        rst_n = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        stallF = 1'b0; redirect = 1'b0; redirect_pc = '0;
        pending = 1'b0; expPc = 32'h0; lastRedirect = 1'b0;
        #1;
        checkOutput("midRstReq", 32'(imem_req), 32'd0);
        checkOutput("midRstValid", 32'(validF), 32'd0);
        checkOutput("midRstPcF", PCF, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("postRstAddr", imem_addr, 32'h0);
        checkOutput("postRstReq", 32'(imem_req), 32'd1);
        for (int i = 0; i < 200; i++) randomCycle();

        // Wrapping PC on the instance that starts at the top of the address space
        checkOutput("dut2Req", 32'(req2), 32'd1);
        checkOutput("dut2Addr", addr2, 32'hFFFF_FFFC);
        @(negedge clk);
        gnt2 = 1'b1;
        @(negedge clk);
        gnt2 = 1'b0; rvalid2 = 1'b1; rdata2 = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        checkOutput("dut2Valid", 32'(validF2), 32'd1);
        checkOutput("dut2PcF", PCF2, 32'hFFFF_FFFC);
        checkOutput("dut2Pc4Wrap", PCPlus4F2, 32'h0);
        checkOutput("dut2Instr", instrF2, 32'hDEAD_BEEF);
        @(negedge clk);
        rvalid2 = 1'b0; rdata2 = '0;
        @(posedge clk);
        #1;
        checkOutput("dut2WrapReq", 32'(req2), 32'd1);
        checkOutput("dut2WrapAddr", addr2, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
